// File: rtl/pbs_pkg.sv
// Shared types and constants for the PBS battle engine and its helpers.
package pbs_pkg;

  typedef enum logic [3:0] {
    ST_P_LOAD  = 4'd0,
    ST_P_CALC  = 4'd1,
    ST_P_APPLY = 4'd2,
    ST_A_LOAD  = 4'd3,
    ST_A_CALC  = 4'd4,
    ST_A_APPLY = 4'd5,
    ST_VICTORY = 4'd6,
    ST_LOSS    = 4'd7,
    ST_DRAW    = 4'd8
  } pbs_state_t;

  localparam int unsigned PBS_MIN_DMG = 1;

endpackage

// File: rtl/pbs_edge_detect.sv
// Registers a level input and produces a one-cycle pulse on its rising edge.
module pbs_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/pbs_battle_engine.sv
// Turn-based battle controller: alternating player/AI turns, HP bookkeeping,
// draw limit and restart from the end states.
module pbs_battle_engine
  import pbs_pkg::*;
#(
  parameter int unsigned HP_W      = 8,
  parameter int unsigned POW_W     = 4,
  parameter int unsigned HP_INIT   = 100,
  parameter int unsigned MAX_TURNS = 32,
  parameter int unsigned TURN_W    = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [POW_W-1:0]  move_in,
  input  logic [POW_W-1:0]  def_p,
  input  logic [POW_W-1:0]  def_a,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   a_hp,
  output logic [POW_W-1:0]  dmg,
  output logic [TURN_W-1:0] turn,
  output logic [3:0]        phase,
  output logic              victory,
  output logic              loss,
  output logic              draw
);

  localparam logic [HP_W-1:0]   HP_START  = HP_W'(HP_INIT);
  localparam logic [POW_W-1:0]  MIN_DMG   = POW_W'(PBS_MIN_DMG);
  localparam logic [TURN_W-1:0] TURN_LIM  = TURN_W'(MAX_TURNS);
  localparam bit                HAS_LIMIT = (MAX_TURNS != 0);

  pbs_state_t        state_q, state_d;
  logic [POW_W-1:0]  mv, mv_d, dmg_d;
  logic [HP_W-1:0]   p_hp_d, a_hp_d;
  logic [TURN_W-1:0] turn_d;
  logic              victory_d, loss_d, draw_d;
  logic              go_rise;

  logic [POW_W-1:0]  dmg_on_ai_c, dmg_on_player_c;
  logic [HP_W-1:0]   dmg_ext, a_hp_hit, p_hp_hit;
  logic [TURN_W-1:0] turn_inc;
  logic              draw_hit;

  pbs_edge_detect u_go_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (go),
    .rise_c  (go_rise)
  );

  // Damage and saturating HP arithmetic, all unsigned.
  assign dmg_on_ai_c     = (mv > def_a) ? mv - def_a : MIN_DMG;
  assign dmg_on_player_c = (mv > def_p) ? mv - def_p : MIN_DMG;
  assign dmg_ext         = HP_W'(dmg);
  assign a_hp_hit        = (a_hp > dmg_ext) ? a_hp - dmg_ext : '0;
  assign p_hp_hit        = (p_hp > dmg_ext) ? p_hp - dmg_ext : '0;
  assign turn_inc        = turn + TURN_W'(1);
  assign draw_hit        = HAS_LIMIT && (turn_inc == TURN_LIM);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_P_LOAD;
      mv      <= '0;
      dmg     <= '0;
      p_hp    <= HP_START;
      a_hp    <= HP_START;
      turn    <= '0;
      victory <= 1'b0;
      loss    <= 1'b0;
      draw    <= 1'b0;
    end else begin
      state_q <= state_d;
      mv      <= mv_d;
      dmg     <= dmg_d;
      p_hp    <= p_hp_d;
      a_hp    <= a_hp_d;
      turn    <= turn_d;
      victory <= victory_d;
      loss    <= loss_d;
      draw    <= draw_d;
    end
  end

  assign phase = state_q;

  always_comb begin
    state_d = state_q;
    mv_d    = mv;
    dmg_d   = dmg;
    p_hp_d  = p_hp;
    a_hp_d  = a_hp;
    turn_d  = turn;

    case (state_q)
      ST_P_LOAD: if (go_rise) begin
        mv_d    = move_in;
        state_d = ST_P_CALC;
      end
      ST_P_CALC: if (go_rise) begin
        dmg_d   = dmg_on_ai_c;
        state_d = ST_P_APPLY;
      end
      ST_P_APPLY: if (go_rise) begin
        a_hp_d  = a_hp_hit;
        state_d = (a_hp_hit == '0) ? ST_VICTORY : ST_A_LOAD;
      end
      ST_A_LOAD: if (go_rise) begin
        mv_d    = move_in;
        state_d = ST_A_CALC;
      end
      ST_A_CALC: if (go_rise) begin
        dmg_d   = dmg_on_player_c;
        state_d = ST_A_APPLY;
      end
      // A knockout ends the round before the turn counter or draw limit apply.
      ST_A_APPLY: if (go_rise) begin
        p_hp_d = p_hp_hit;
        if (p_hp_hit == '0) begin
          state_d = ST_LOSS;
        end else begin
          turn_d  = turn_inc;
          state_d = draw_hit ? ST_DRAW : ST_P_LOAD;
        end
      end
      ST_VICTORY, ST_LOSS, ST_DRAW: if (go_rise) begin
        p_hp_d  = HP_START;
        a_hp_d  = HP_START;
        turn_d  = '0;
        dmg_d   = '0;
        mv_d    = '0;
        state_d = ST_P_LOAD;
      end
      default: state_d = ST_P_LOAD;
    endcase

    victory_d = (state_d == ST_VICTORY);
    loss_d    = (state_d == ST_LOSS);
    draw_d    = (state_d == ST_DRAW);
  end

endmodule

// File: tb/tb_pbs_battle_engine.sv
// Directed bench for pbs_battle_engine: three instances cover default,
// low-HP knockout and short draw-limit configurations.
module tb_pbs_battle_engine;

  logic       clk = 1'b0;
  logic       reset_n [3];
  logic       go      [3];
  logic [3:0] move_in [3];
  logic [3:0] def_p   [3];
  logic [3:0] def_a   [3];
  logic [7:0] p_hp    [3];
  logic [7:0] a_hp    [3];
  logic [3:0] dmg     [3];
  logic [5:0] turn    [3];
  logic [3:0] phase   [3];
  logic       victory [3];
  logic       loss    [3];
  logic       draw    [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pbs_battle_engine u_dut_def (
    .clk(clk), .reset_n(reset_n[0]), .go(go[0]), .move_in(move_in[0]),
    .def_p(def_p[0]), .def_a(def_a[0]), .p_hp(p_hp[0]), .a_hp(a_hp[0]),
    .dmg(dmg[0]), .turn(turn[0]), .phase(phase[0]),
    .victory(victory[0]), .loss(loss[0]), .draw(draw[0])
  );

  pbs_battle_engine #(.HP_INIT(5)) u_dut_ko (
    .clk(clk), .reset_n(reset_n[1]), .go(go[1]), .move_in(move_in[1]),
    .def_p(def_p[1]), .def_a(def_a[1]), .p_hp(p_hp[1]), .a_hp(a_hp[1]),
    .dmg(dmg[1]), .turn(turn[1]), .phase(phase[1]),
    .victory(victory[1]), .loss(loss[1]), .draw(draw[1])
  );

  pbs_battle_engine #(.HP_INIT(20), .MAX_TURNS(2)) u_dut_draw (
    .clk(clk), .reset_n(reset_n[2]), .go(go[2]), .move_in(move_in[2]),
    .def_p(def_p[2]), .def_a(def_a[2]), .p_hp(p_hp[2]), .a_hp(a_hp[2]),
    .dmg(dmg[2]), .turn(turn[2]), .phase(phase[2]),
    .victory(victory[2]), .loss(loss[2]), .draw(draw[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One go pulse: high across one edge, low across the next.
  task automatic pulse(input int k);
    go[k] = 1'b1;
    tick();
    go[k] = 1'b0;
    tick();
  endtask

  task automatic full_round(input int k, input logic [3:0] pm, input logic [3:0] am);
    move_in[k] = pm;
    for (int i = 0; i < 3; i++) pulse(k);
    move_in[k] = am;
    for (int i = 0; i < 3; i++) pulse(k);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset_n[k] = 1'b0;
      go[k]      = 1'b0;
      move_in[k] = 4'd0;
      def_p[k]   = 4'd5;
      def_a[k]   = 4'd3;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) reset_n[k] = 1'b1;
    tick();

    check("rst_p_hp",  32'(p_hp[0]),  32'd100);
    check("rst_a_hp",  32'(a_hp[0]),  32'd100);
    check("rst_dmg",   32'(dmg[0]),   32'd0);
    check("rst_turn",  32'(turn[0]),  32'd0);
    check("rst_phase", 32'(phase[0]), 32'd0);
    check("rst_flags", 32'({victory[0], loss[0], draw[0]}), 32'd0);

    // Level-held go advances exactly one state.
    move_in[0] = 4'd9;
    go[0] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    go[0] = 1'b0;
    tick();
    check("hold_phase", 32'(phase[0]), 32'd1);

    // Finish the first round: 9-3=6 on AI, 9-5=4 on player.
    pulse(0);
    check("r1_pdmg", 32'(dmg[0]), 32'd6);
    for (int i = 0; i < 4; i++) pulse(0);
    check("r1_a_hp",  32'(a_hp[0]),  32'd94);
    check("r1_p_hp",  32'(p_hp[0]),  32'd96);
    check("r1_turn",  32'(turn[0]),  32'd1);
    check("r1_phase", 32'(phase[0]), 32'd0);
    check("r1_dmg",   32'(dmg[0]),   32'd4);

    // Weak move against strong defence still deals the minimum of 1.
    move_in[0] = 4'd2;
    def_a[0]   = 4'd7;
    pulse(0);
    pulse(0);
    check("min_dmg", 32'(dmg[0]), 32'd1);
    pulse(0);
    check("min_a_hp",  32'(a_hp[0]),  32'd93);
    check("min_phase", 32'(phase[0]), 32'd3);

    // Reset mid-battle from A_CALC.
    move_in[0] = 4'd9;
    pulse(0);
    check("pre_rst_phase", 32'(phase[0]), 32'd4);
    reset_n[0] = 1'b0;
    go[0]      = 1'b1;
    tick();
    check("mrst_p_hp",  32'(p_hp[0]),  32'd100);
    check("mrst_a_hp",  32'(a_hp[0]),  32'd100);
    check("mrst_dmg",   32'(dmg[0]),   32'd0);
    check("mrst_turn",  32'(turn[0]),  32'd0);
    check("mrst_phase", 32'(phase[0]), 32'd0);
    check("mrst_flags", 32'({victory[0], loss[0], draw[0]}), 32'd0);
    // go already high in the first cycle after reset counts as a rise.
    reset_n[0] = 1'b1;
    tick();
    check("post_rst_rise", 32'(phase[0]), 32'd1);
    go[0] = 1'b0;
    tick();

    // Knockout saturates AI HP at 0 (5 - 15 would wrap).
    move_in[1] = 4'd15;
    def_a[1]   = 4'd0;
    for (int i = 0; i < 3; i++) pulse(1);
    check("ko_a_hp",    32'(a_hp[1]),    32'd0);
    check("ko_victory", 32'(victory[1]), 32'd1);
    check("ko_phase",   32'(phase[1]),   32'd6);
    check("ko_dmg",     32'(dmg[1]),     32'd15);
    pulse(1);
    check("rs_p_hp",    32'(p_hp[1]),    32'd5);
    check("rs_a_hp",    32'(a_hp[1]),    32'd5);
    check("rs_phase",   32'(phase[1]),   32'd0);
    check("rs_victory", 32'(victory[1]), 32'd0);
    check("rs_dmg",     32'(dmg[1]),     32'd0);

    // Two low-damage rounds reach the draw limit.
    def_a[2] = 4'd5;
    def_p[2] = 4'd5;
    full_round(2, 4'd1, 4'd1);
    check("d1_turn",  32'(turn[2]),  32'd1);
    check("d1_phase", 32'(phase[2]), 32'd0);
    full_round(2, 4'd1, 4'd1);
    check("d2_draw",  32'(draw[2]),  32'd1);
    check("d2_turn",  32'(turn[2]),  32'd2);
    check("d2_phase", 32'(phase[2]), 32'd8);
    check("d2_hp",    32'({p_hp[2], a_hp[2]}), 32'({8'd18, 8'd18}));
    pulse(2);
    check("d_restart", 32'({phase[2], turn[2], p_hp[2]}), 32'({4'd0, 6'd0, 8'd20}));

    // Player knocked out on the limit round: loss wins over draw.
    def_p[2] = 4'd0;
    full_round(2, 4'd1, 4'd15);
    check("l1_p_hp", 32'(p_hp[2]), 32'd5);
    full_round(2, 4'd1, 4'd15);
    check("l2_loss",  32'(loss[2]),  32'd1);
    check("l2_draw",  32'(draw[2]),  32'd0);
    check("l2_phase", 32'(phase[2]), 32'd7);
    check("l2_turn",  32'(turn[2]),  32'd1);
    check("l2_p_hp",  32'(p_hp[2]),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
